// File: rtl/am_class_sequencer.sv
// Class-HV sequencer: streams class HVs from SRAM into assoc_mem via a 2-entry skid FIFO.
// Optional stall counter port enabled by defining AM_SEQ_PERF_CNT_EN.
module am_class_sequencer #(
  parameter int unsigned HVDimension     = 512,
  parameter int unsigned DataWidth       = 8,
  parameter int unsigned AddrWidth       = 10,
  parameter int unsigned ExtCounterWidth = 5,
  parameter int unsigned MaxClasses      = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic [DataWidth-1:0]       num_class_i,
  input  logic                       extend_enable_i,
  input  logic [ExtCounterWidth-1:0] extend_count_i,
  input  logic [AddrWidth-1:0]       base_addr_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       error_o,
  output logic                       mem_req_o,
  output logic [AddrWidth-1:0]       mem_addr_o,
  input  logic [HVDimension-1:0]     mem_rdata_i,
  output logic [HVDimension-1:0]     class_hv_o,
  output logic                       class_hv_valid_o,
`ifdef AM_SEQ_PERF_CNT_EN
  output logic [15:0]                perf_stall_cnt_o,
`endif
  input  logic                       class_hv_ready_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_e;

  state_e                     r_state;
  logic [DataWidth-1:0]       r_num_class;
  logic                       r_ext_en;
  logic [ExtCounterWidth-1:0] r_ext_cnt;
  logic [AddrWidth-1:0]       r_base;
  logic [DataWidth-1:0]       r_class_idx;
  logic [ExtCounterWidth-1:0] r_pass_idx;
  logic                       r_inflight;
  logic [HVDimension-1:0]     r_fifo [2];
  logic                       r_wr_ptr;
  logic                       r_rd_ptr;
  logic [1:0]                 r_count;
  logic                       r_done;
  logic                       r_error;

  logic                       w_valid;
  logic                       w_pop;
  logic                       w_push;
  logic [2:0]                 w_used;
  logic                       w_req;
  logic [ExtCounterWidth-1:0] w_passes;
  logic                       w_class_wrap;
  logic                       w_last_rd;
  logic                       w_last_hs;
  logic                       w_cfg_bad;
  logic                       w_start_ok;

  assign w_valid = (r_count != 2'd0);
  assign w_pop   = w_valid & class_hv_ready_i;
  assign w_push  = r_inflight;

  // A pop in this cycle frees its slot for a read issued in the same cycle.
  assign w_used = {1'b0, r_count} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_req  = (r_state == S_RUN) && (w_used < 3'd2);

  assign w_passes     = r_ext_en ? r_ext_cnt : ExtCounterWidth'(1);
  assign w_class_wrap = (r_class_idx == r_num_class - DataWidth'(1));
  assign w_last_rd    = w_req && w_class_wrap
                     && (r_pass_idx == w_passes - ExtCounterWidth'(1));
  assign w_last_hs    = (r_state == S_DRAIN) && w_pop
                     && (r_count == 2'd1) && !r_inflight;

  assign w_cfg_bad  = (num_class_i == '0)
                   || (32'(num_class_i) > MaxClasses)
                   || (extend_enable_i && (extend_count_i == '0));
  assign w_start_ok = (r_state == S_IDLE) && start_i && !w_cfg_bad;

  assign busy_o           = (r_state != S_IDLE);
  assign done_o           = r_done;
  assign error_o          = r_error;
  assign mem_req_o        = w_req;
  assign mem_addr_o       = r_base + AddrWidth'(r_class_idx);
  assign class_hv_o       = r_fifo[r_rd_ptr];
  assign class_hv_valid_o = w_valid;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_num_class <= '0;
      r_ext_en    <= 1'b0;
      r_ext_cnt   <= '0;
      r_base      <= '0;
      r_class_idx <= '0;
      r_pass_idx  <= '0;
      r_inflight  <= 1'b0;
      r_fifo[0]   <= '0;
      r_fifo[1]   <= '0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= 2'd0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_inflight <= w_req;
      if (w_push) begin
        r_fifo[r_wr_ptr] <= mem_rdata_i;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};

      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            if (w_cfg_bad) begin
              r_error <= 1'b1;
            end else begin
              r_num_class <= num_class_i;
              r_ext_en    <= extend_enable_i;
              r_ext_cnt   <= extend_count_i;
              r_base      <= base_addr_i;
              r_class_idx <= '0;
              r_pass_idx  <= '0;
              r_state     <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (!abort_i && w_req) begin
            if (w_class_wrap) begin
              r_class_idx <= '0;
              r_pass_idx  <= r_pass_idx + ExtCounterWidth'(1);
            end else begin
              r_class_idx <= r_class_idx + DataWidth'(1);
            end
            if (w_last_rd) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!abort_i && w_last_hs) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Abort flushes the FIFO and forgets any read still in flight.
      if (abort_i && (r_state != S_IDLE)) begin
        r_state    <= S_IDLE;
        r_count    <= 2'd0;
        r_wr_ptr   <= 1'b0;
        r_rd_ptr   <= 1'b0;
        r_inflight <= 1'b0;
      end
    end
  end

`ifdef AM_SEQ_PERF_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_stall_cnt <= 16'd0;
    end else if (w_start_ok) begin
      r_stall_cnt <= 16'd0;
    end else if (busy_o && w_valid && !class_hv_ready_i
                 && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign perf_stall_cnt_o = r_stall_cnt;
`endif

endmodule
